// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one line-wide memory port between the I$ (read-only line fills)
//   and the D$ (line fills and line writes). One transaction is outstanding
//   at a time. The grant is held until memory signals completion. Round-robin
//   on contention uses lastGrant.
//
// Ports
//   clk, rstN                      clock, asynchronous active-low reset
//   icacheReadEnable/icacheAddr    I$ fill request and line address
//   icacheReadDone/icacheReadValue I$ fill completion pulse and data
//   dcacheReadEnable/WriteEnable   D$ fill / write requests
//   dcacheAddr/dcacheWriteValue    D$ line address and write line
//   dcacheReadDone/WriteDone       D$ completion pulses
//   dcacheReadValue                D$ fill data
//   memAddr/memWriteValue          registered line address and write line
//   memReadEnable/memWriteEnable   decoded from the registered state
//   memReadValue/ReadDone/WriteDone memory read data and completion pulses
module cache_mem_arbiter #(
  parameter int unsigned MemAddrWidth = 30,
  parameter int unsigned LineWidth    = 128
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    icacheReadEnable,
  input  logic [MemAddrWidth-1:0] icacheAddr,
  output logic                    icacheReadDone,
  output logic [LineWidth-1:0]    icacheReadValue,
  input  logic                    dcacheReadEnable,
  input  logic                    dcacheWriteEnable,
  input  logic [MemAddrWidth-1:0] dcacheAddr,
  input  logic [LineWidth-1:0]    dcacheWriteValue,
  output logic                    dcacheReadDone,
  output logic                    dcacheWriteDone,
  output logic [LineWidth-1:0]    dcacheReadValue,
  output logic [MemAddrWidth-1:0] memAddr,
  output logic                    memReadEnable,
  output logic                    memWriteEnable,
  output logic [LineWidth-1:0]    memWriteValue,
  input  logic [LineWidth-1:0]    memReadValue,
  input  logic                    memReadDone,
  input  logic                    memWriteDone
);

  typedef enum logic [1:0] {
    StIdle,
    StICacheRead,
    StDCacheRead,
    StDCacheWrite
  } state_e;

  typedef enum logic {
    GrantI,
    GrantD
  } grant_e;

  state_e                  state_q, state_d;
  grant_e                  last_grant_q, last_grant_d;
  logic [MemAddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [LineWidth-1:0]    mem_wval_q, mem_wval_d;
  logic                    dcache_req;
  logic                    pick_dcache;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wval_d   = mem_wval_q;
    dcache_req   = dcacheReadEnable | dcacheWriteEnable;
    // D$ wins when it is the only requester, or on contention when I$ had
    // the previous grant.
    pick_dcache  = dcache_req & (~icacheReadEnable | (last_grant_q == GrantI));

    unique case (state_q)
      StIdle: begin
        if (pick_dcache) begin
          last_grant_d = GrantD;
          mem_addr_d   = dcacheAddr;
          // A simultaneous D$ read stays pending and re-arbitrates later.
          if (dcacheWriteEnable) begin
            state_d    = StDCacheWrite;
            mem_wval_d = dcacheWriteValue;
          end else begin
            state_d    = StDCacheRead;
          end
        end else if (icacheReadEnable) begin
          state_d      = StICacheRead;
          last_grant_d = GrantI;
          mem_addr_d   = icacheAddr;
        end
      end
      StICacheRead, StDCacheRead: begin
        if (memReadDone) state_d = StIdle;
      end
      StDCacheWrite: begin
        if (memWriteDone) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StIdle;
      last_grant_q <= GrantD;
      mem_addr_q   <= '0;
      mem_wval_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wval_q   <= mem_wval_d;
    end
  end

  assign memAddr         = mem_addr_q;
  assign memWriteValue   = mem_wval_q;
  assign memReadEnable   = (state_q == StICacheRead) | (state_q == StDCacheRead);
  assign memWriteEnable  = (state_q == StDCacheWrite);

  assign icacheReadDone  = (state_q == StICacheRead)  & memReadDone;
  assign dcacheReadDone  = (state_q == StDCacheRead)  & memReadDone;
  assign dcacheWriteDone = (state_q == StDCacheWrite) & memWriteDone;

  assign icacheReadValue = memReadValue;
  assign dcacheReadValue = memReadValue;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Table of per-cycle vectors (inputs applied at the falling edge, outputs
//   checked 1 ns later), followed by a hand-written reset-during-write
//   sequence.
module tb_cache_mem_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rstN;
  logic          icacheReadEnable;
  logic [AW-1:0] icacheAddr;
  logic          icacheReadDone;
  logic [LW-1:0] icacheReadValue;
  logic          dcacheReadEnable;
  logic          dcacheWriteEnable;
  logic [AW-1:0] dcacheAddr;
  logic [LW-1:0] dcacheWriteValue;
  logic          dcacheReadDone;
  logic          dcacheWriteDone;
  logic [LW-1:0] dcacheReadValue;
  logic [AW-1:0] memAddr;
  logic          memReadEnable;
  logic          memWriteEnable;
  logic [LW-1:0] memWriteValue;
  logic [LW-1:0] memReadValue;
  logic          memReadDone;
  logic          memWriteDone;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.MemAddrWidth(AW), .LineWidth(LW)) dut (
    .clk               (clk),
    .rstN              (rstN),
    .icacheReadEnable  (icacheReadEnable),
    .icacheAddr        (icacheAddr),
    .icacheReadDone    (icacheReadDone),
    .icacheReadValue   (icacheReadValue),
    .dcacheReadEnable  (dcacheReadEnable),
    .dcacheWriteEnable (dcacheWriteEnable),
    .dcacheAddr        (dcacheAddr),
    .dcacheWriteValue  (dcacheWriteValue),
    .dcacheReadDone    (dcacheReadDone),
    .dcacheWriteDone   (dcacheWriteDone),
    .dcacheReadValue   (dcacheReadValue),
    .memAddr           (memAddr),
    .memReadEnable     (memReadEnable),
    .memWriteEnable    (memWriteEnable),
    .memWriteValue     (memWriteValue),
    .memReadValue      (memReadValue),
    .memReadDone       (memReadDone),
    .memWriteDone      (memWriteDone)
  );

  typedef struct {
    logic          rst_n;
    logic          ic_re;
    logic [AW-1:0] ic_a;
    logic          dc_re;
    logic          dc_we;
    logic [AW-1:0] dc_a;
    logic [LW-1:0] dc_wv;
    logic [LW-1:0] mrv;
    logic          mrd;
    logic          mwd;
    logic          x_mre;
    logic          x_mwe;
    logic [AW-1:0] x_addr;
    logic [LW-1:0] x_wv;
    logic          x_icd;
    logic          x_dcrd;
    logic          x_dcwd;
  } vec_t;

  localparam logic [LW-1:0] A5 = {16{8'hA5}};
  localparam logic [LW-1:0] C3 = {16{8'h3C}};
  localparam logic [LW-1:0] WV = 128'h0123456789ABCDEF_FEDCBA9876543210;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst_n, input logic ic_re, input logic [AW-1:0] ic_a,
    input logic dc_re, input logic dc_we, input logic [AW-1:0] dc_a,
    input logic [LW-1:0] dc_wv, input logic [LW-1:0] mrv,
    input logic mrd, input logic mwd,
    input logic x_mre, input logic x_mwe, input logic [AW-1:0] x_addr,
    input logic [LW-1:0] x_wv, input logic x_icd, input logic x_dcrd,
    input logic x_dcwd);
    vec_t v;
    v.rst_n = rst_n; v.ic_re = ic_re; v.ic_a = ic_a;
    v.dc_re = dc_re; v.dc_we = dc_we; v.dc_a = dc_a; v.dc_wv = dc_wv;
    v.mrv = mrv; v.mrd = mrd; v.mwd = mwd;
    v.x_mre = x_mre; v.x_mwe = x_mwe; v.x_addr = x_addr; v.x_wv = x_wv;
    v.x_icd = x_icd; v.x_dcrd = x_dcrd; v.x_dcwd = x_dcwd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rstN              = v.rst_n;
    icacheReadEnable  = v.ic_re;
    icacheAddr        = v.ic_a;
    dcacheReadEnable  = v.dc_re;
    dcacheWriteEnable = v.dc_we;
    dcacheAddr        = v.dc_a;
    dcacheWriteValue  = v.dc_wv;
    memReadValue      = v.mrv;
    memReadDone       = v.mrd;
    memWriteDone      = v.mwd;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, ".memReadEnable"},   LW'(memReadEnable),   LW'(v.x_mre));
    chk({p, ".memWriteEnable"},  LW'(memWriteEnable),  LW'(v.x_mwe));
    chk({p, ".memAddr"},         LW'(memAddr),         LW'(v.x_addr));
    chk({p, ".memWriteValue"},   memWriteValue,        v.x_wv);
    chk({p, ".icacheReadDone"},  LW'(icacheReadDone),  LW'(v.x_icd));
    chk({p, ".dcacheReadDone"},  LW'(dcacheReadDone),  LW'(v.x_dcrd));
    chk({p, ".dcacheWriteDone"}, LW'(dcacheWriteDone), LW'(v.x_dcwd));
    chk({p, ".icacheReadValue"}, icacheReadValue,      v.mrv);
    chk({p, ".dcacheReadValue"}, dcacheReadValue,      v.mrv);
  endtask

  initial begin
    vec_t idle_v;
    bit   seen;

    //       rst ic icA      dre dwe dcA      dcWV mrv mrd mwd | mre mwe addr     wv  icd drd dwd
    // Reset with both requesting, then release: I$ wins (lastGrant=D).
    vecs.push_back(mk(0, 1, 30'h1234, 1, 0, 30'h0777, '0, '0, 0, 0,  0, 0, 30'h0,    '0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 30'h1234, 1, 0, 30'h0777, '0, '0, 0, 0,  0, 0, 30'h0,    '0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h1234, 1, 0, 30'h0777, '0, '0, 0, 0,  0, 0, 30'h0,    '0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h1234, 1, 0, 30'h0777, '0, '0, 0, 0,  1, 0, 30'h1234, '0, 0, 0, 0));
    // Spurious memWriteDone and an address change while in ICacheRead.
    vecs.push_back(mk(1, 1, 30'h0ABC, 1, 0, 30'h0777, '0, '0, 0, 1,  1, 0, 30'h1234, '0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h1234, 1, 0, 30'h0777, '0, A5, 1, 0,  1, 0, 30'h1234, '0, 1, 0, 0));
    // Idle cycle with a spurious memReadDone; held D$ read granted next.
    vecs.push_back(mk(1, 0, 30'h0,    1, 0, 30'h0777, '0, C3, 1, 0,  0, 0, 30'h1234, '0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 30'h0,    1, 0, 30'h0777, '0, '0, 0, 0,  1, 0, 30'h0777, '0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 30'h0,    1, 0, 30'h0777, '0, C3, 1, 0,  1, 0, 30'h0777, '0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 30'h0,    0, 0, 30'h0,    '0, '0, 0, 0,  0, 0, 30'h0777, '0, 0, 0, 0));
    // D$ read+write together: write first, data/address changes ignored.
    vecs.push_back(mk(1, 0, 30'h0,    1, 1, 30'h55,   WV, '0, 0, 0,  0, 0, 30'h0777, '0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 30'h0,    1, 1, 30'h66,   C3, '0, 1, 0,  0, 1, 30'h55,   WV, 0, 0, 0));
    vecs.push_back(mk(1, 0, 30'h0,    1, 1, 30'h55,   WV, '0, 0, 1,  0, 1, 30'h55,   WV, 0, 0, 1));
    vecs.push_back(mk(1, 0, 30'h0,    1, 0, 30'h55,   WV, '0, 0, 0,  0, 0, 30'h55,   WV, 0, 0, 0));
    vecs.push_back(mk(1, 0, 30'h0,    1, 0, 30'h55,   WV, '0, 0, 0,  1, 0, 30'h55,   WV, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h2000, 1, 0, 30'h55,   WV, A5, 1, 0,  1, 0, 30'h55,   WV, 0, 1, 0));
    // Contention with lastGrant=D: I$ wins.
    vecs.push_back(mk(1, 1, 30'h2000, 1, 0, 30'h99,   '0, '0, 0, 0,  0, 0, 30'h55,   WV, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h2000, 1, 0, 30'h99,   '0, '0, 0, 0,  1, 0, 30'h2000, WV, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h2000, 1, 0, 30'h99,   '0, C3, 1, 0,  1, 0, 30'h2000, WV, 1, 0, 0));
    // Contention with lastGrant=I: D$ wins.
    vecs.push_back(mk(1, 1, 30'h3000, 1, 0, 30'h99,   '0, '0, 0, 0,  0, 0, 30'h2000, WV, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h3000, 1, 0, 30'h99,   '0, '0, 0, 0,  1, 0, 30'h99,   WV, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h3000, 1, 0, 30'h99,   '0, A5, 1, 0,  1, 0, 30'h99,   WV, 0, 1, 0));
    vecs.push_back(mk(1, 1, 30'h3000, 0, 0, 30'h0,    '0, '0, 0, 0,  0, 0, 30'h99,   WV, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h3000, 0, 0, 30'h0,    '0, '0, 0, 0,  1, 0, 30'h3000, WV, 0, 0, 0));
    vecs.push_back(mk(1, 1, 30'h3000, 0, 0, 30'h0,    '0, C3, 1, 0,  1, 0, 30'h3000, WV, 1, 0, 0));
    vecs.push_back(mk(1, 0, 30'h0,    0, 0, 30'h0,    '0, '0, 0, 0,  0, 0, 30'h3000, WV, 0, 0, 0));

    idle_v = mk(0, 0, '0, 0, 0, '0, '0, '0, 0, 0, 0, 0, '0, '0, 0, 0, 0);
    drive(idle_v);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
      chk($sformatf("v%0d.oneDone", i),
          LW'(int'(icacheReadDone) + int'(dcacheReadDone) + int'(dcacheWriteDone) <= 1), LW'(1));
    end

    // Reset asserted in the middle of a D$ write.
    @(negedge clk);
    dcacheWriteEnable = 1'b1;
    dcacheAddr        = 30'h44;
    dcacheWriteValue  = C3;
    @(negedge clk);
    #1;
    chk("rstw.granted.memWriteEnable", LW'(memWriteEnable), LW'(1));
    chk("rstw.granted.memAddr",        LW'(memAddr),        LW'(30'h44));
    chk("rstw.granted.memWriteValue",  memWriteValue,       C3);
    memWriteDone = 1'b1;
    #1;
    rstN = 1'b0;
    #1;
    chk("rstw.abort.memWriteEnable",  LW'(memWriteEnable),  LW'(0));
    chk("rstw.abort.dcacheWriteDone", LW'(dcacheWriteDone), LW'(0));
    chk("rstw.abort.memAddr",         LW'(memAddr),         LW'(0));
    chk("rstw.abort.memWriteValue",   memWriteValue,        '0);
    memWriteDone = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("rstw.release.memWriteEnable", LW'(memWriteEnable), LW'(0));
    @(negedge clk);
    #1;
    chk("rstw.regrant.memWriteEnable", LW'(memWriteEnable), LW'(1));
    chk("rstw.regrant.memAddr",        LW'(memAddr),        LW'(30'h44));
    chk("rstw.regrant.memWriteValue",  memWriteValue,       C3);

    // Complete the re-granted write after a short memory delay, bounded wait.
    repeat (2) @(negedge clk);
    memWriteDone = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      #1;
      if (dcacheWriteDone) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rstw.complete.dcacheWriteDone", LW'(seen), LW'(1));
    @(negedge clk);
    memWriteDone      = 1'b0;
    dcacheWriteEnable = 1'b0;
    #1;
    chk("rstw.idle.memWriteEnable", LW'(memWriteEnable), LW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
